// File: rtl/line_window_pkg.sv
// line_window_pkg: shared types, defaults and width helper for the line window generator.
package line_window_pkg;
    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int COL_W          = $clog2(IMG_WIDTH_DEF);
    localparam int ROW_W          = $clog2(IMG_HEIGHT_DEF);

    typedef enum logic {FILL, STREAM} state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/line_window_gen_ram.sv
// line_ram: simple dual-port line memory, synchronous write and asynchronous read.
module line_ram
    import line_window_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/line_window_gen.sv
// line_window_gen: raster stream to 3-pixel vertical column window using two ping-pong line RAMs.
// Optional LINE_WINDOW_SOF_EN adds i_sof, which forces the accepted pixel to be (0,0).
module line_window_gen
    import line_window_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PIX_W-1:0] i_pixel,
    input  logic             i_pixel_valid,
`ifdef LINE_WINDOW_SOF_EN
    input  logic             i_sof,
`endif
    output logic             o_pixel_ack,
    output logic [PIX_W-1:0] o_pixel_1,
    output logic [PIX_W-1:0] o_pixel_2,
    output logic [PIX_W-1:0] o_pixel_3,
    output logic             o_pixel_valid,
    input  logic             i_pixel_ack,
    output logic             o_frame_done
);
    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);

    state_t           r_state, w_state, w_state_nxt;
    logic [CW-1:0]    r_col, w_col;
    logic [RW-1:0]    r_row, w_row;
    logic             r_sel, w_sel;
    logic             r_valid, r_done;
    logic [PIX_W-1:0] r_p1, r_p2, r_p3;
    logic [PIX_W-1:0] w_rd_a, w_rd_b;
    logic             w_xfer, w_oxfer, w_last_col, w_last_row, w_load;

    assign w_xfer  = i_pixel_valid & o_pixel_ack;
    assign w_oxfer = r_valid & i_pixel_ack;

`ifdef LINE_WINDOW_SOF_EN
    logic w_sof;
    assign w_sof   = i_sof & w_xfer;
    assign w_col   = w_sof ? '0 : r_col;
    assign w_row   = w_sof ? '0 : r_row;
    assign w_sel   = w_sof ? 1'b0 : r_sel;
    assign w_state = w_sof ? FILL : r_state;
`else
    assign w_col   = r_col;
    assign w_row   = r_row;
    assign w_sel   = r_sel;
    assign w_state = r_state;
`endif

    assign w_last_col = w_col == CW'(IMG_WIDTH - 1);
    assign w_last_row = w_row == RW'(IMG_HEIGHT - 1);
    assign w_load     = w_xfer & (w_state == STREAM);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= FILL;
        else          r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = !w_xfer                          ? r_state :
                      (w_last_col && w_last_row)       ? FILL    :
                      (w_last_col && w_row == RW'(1))  ? STREAM  : w_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_sel <= 1'b0;
        end else if (w_xfer) begin
            r_col <= w_last_col ? '0 : w_col + CW'(1);
            r_row <= !w_last_col ? w_row : w_last_row ? '0 : w_row + RW'(1);
            r_sel <= !w_last_col ? w_sel : ~w_last_row & ~w_sel;
        end

    // r_sel names the RAM holding row r-1; the other one is overwritten with row r
    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_ram_a (
        .i_clk(i_clk), .i_we(w_xfer & w_sel), .i_waddr(w_col),
        .i_wdata(i_pixel), .i_raddr(w_col), .o_rdata(w_rd_a)
    );

    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_ram_b (
        .i_clk(i_clk), .i_we(w_xfer & ~w_sel), .i_waddr(w_col),
        .i_wdata(i_pixel), .i_raddr(w_col), .o_rdata(w_rd_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_p3    <= '0;
        end else begin
            r_done <= w_xfer & w_last_col & w_last_row;
            if (w_load) begin
                r_valid <= 1'b1;
                r_p1    <= w_sel ? w_rd_a : w_rd_b;
                r_p2    <= w_sel ? w_rd_b : w_rd_a;
                r_p3    <= i_pixel;
            end else if (w_oxfer) begin
                r_valid <= 1'b0;
            end
        end

    assign o_pixel_ack   = ~r_valid | i_pixel_ack;
    assign o_pixel_valid = r_valid;
    assign o_pixel_1     = r_p1;
    assign o_pixel_2     = r_p2;
    assign o_pixel_3     = r_p3;
    assign o_frame_done  = r_done;
endmodule

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen: scoreboard bench for line_window_gen at 4x4, pixel = base + row*16 + col.
module tb_line_window_gen;
    typedef struct {
        logic [23:0] win;
        int          idx;
        logic [7:0]  base;
    } ent_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_pixel = '0;
    logic       i_pixel_valid = 1'b0;
    logic       i_sof_v = 1'b0;
    logic       i_pixel_ack = 1'b1;
    logic       o_pixel_ack, o_pixel_valid, o_frame_done;
    logic [7:0] o_pixel_1, o_pixel_2, o_pixel_3;

    int   total = 0, bad = 0;
    ent_t q[$];
    logic [7:0] mem [4][4];
    int   m_row = 0, m_col = 0, outs = 0, dones = 0, hold_cnt = 0;
    logic pend_done = 0, pend_load = 0, held = 0;
    logic [23:0] held_win = '0;
    logic bp_en = 0, ack_rand = 0, chk_const = 1;
    logic [7:0] cur_base = '0;

    line_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid),
`ifdef LINE_WINDOW_SOF_EN
        .i_sof(i_sof_v),
`endif
        .o_pixel_ack(o_pixel_ack), .o_pixel_1(o_pixel_1), .o_pixel_2(o_pixel_2),
        .o_pixel_3(o_pixel_3), .o_pixel_valid(o_pixel_valid), .i_pixel_ack(i_pixel_ack),
        .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int idx, input logic [7:0] b);
        int r, c;
        r = idx / 4 + 2;
        c = idx % 4;
        return {8'(b + (r - 2) * 16 + c), 8'(b + (r - 1) * 16 + c), 8'(b + r * 16 + c)};
    endfunction

    // monitor + scoreboard: everything sampled mid-cycle, describing the coming posedge
    always begin
        @(negedge i_clk);
        #1;
        if (!i_rst_n) begin
            q.delete();
            m_row = 0; m_col = 0;
            pend_done = 0; pend_load = 0; held = 0;
        end else begin
            chk("ack", {31'd0, o_pixel_ack}, {31'd0, ~o_pixel_valid | i_pixel_ack});
            chk("done", {31'd0, o_frame_done}, {31'd0, pend_done});
            if (pend_load) chk("lat", {31'd0, o_pixel_valid}, 1);
            if (o_frame_done) dones++;
            if (held && o_pixel_valid) chk("hold", {8'd0, o_pixel_1, o_pixel_2, o_pixel_3}, {8'd0, held_win});
            if (o_pixel_valid && !i_pixel_ack && bp_en) chk("stall", {31'd0, o_pixel_ack}, 0);
            held = o_pixel_valid & ~i_pixel_ack;
            held_win = {o_pixel_1, o_pixel_2, o_pixel_3};
            if (o_pixel_valid) chk("spur", q.size(), (q.size() > 0) ? q.size() : 1);
            if (o_pixel_valid && i_pixel_ack && q.size() > 0) begin
                ent_t e;
                e = q.pop_front();
                chk("win", {8'd0, o_pixel_1, o_pixel_2, o_pixel_3}, {8'd0, e.win});
                if (chk_const) chk("pat", {8'd0, o_pixel_1, o_pixel_2, o_pixel_3}, {8'd0, pat(e.idx, e.base)});
                outs++;
            end
            pend_done = 0;
            pend_load = 0;
            if (i_pixel_valid && o_pixel_ack) begin
`ifdef LINE_WINDOW_SOF_EN
                if (i_sof_v) begin m_row = 0; m_col = 0; end
`endif
                if (m_row >= 2) begin
                    ent_t e;
                    e.win  = {mem[m_row-2][m_col], mem[m_row-1][m_col], i_pixel};
                    e.idx  = (m_row - 2) * 4 + m_col;
                    e.base = cur_base;
                    q.push_back(e);
                    pend_load = 1;
                end
                mem[m_row][m_col] = i_pixel;
                pend_done = (m_row == 3 && m_col == 3);
                m_col++;
                if (m_col == 4) begin
                    m_col = 0;
                    m_row = (m_row == 3) ? 0 : m_row + 1;
                end
            end
        end
    end

    always begin
        @(negedge i_clk);
        if (bp_en && hold_cnt < 4 && o_pixel_valid && q.size() > 0 && q[0].idx == 1) begin
            i_pixel_ack = 1'b0;
            hold_cnt++;
        end else begin
            i_pixel_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [7:0] p, input logic sof, input int gap);
        int n;
        repeat (gap) @(negedge i_clk);
        i_pixel = p;
        i_sof_v = sof;
        i_pixel_valid = 1'b1;
        #1;
        n = 0;
        while (!o_pixel_ack && n < 500) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (n >= 500) chk("in_timeout", 0, 1);
        @(negedge i_clk);
        i_pixel_valid = 1'b0;
        i_sof_v = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int gmax);
        cur_base = b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(8'(b + r * 16 + c), 1'b0, $urandom_range(0, gmax));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || o_pixel_valid) && n < 300) begin
            @(negedge i_clk);
            #2;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic do_reset(input logic pre_exp);
        logic pre;
        i_pixel_valid = 1'b0;
        pre = o_pixel_valid;
        i_rst_n = 1'b0;
        #2;
        chk("rst_pre_valid", {31'd0, pre}, {31'd0, pre_exp});
        chk("rst_async_valid", {31'd0, o_pixel_valid}, 0);
        chk("rst_pix", {8'd0, o_pixel_1, o_pixel_2, o_pixel_3}, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_frames(input string tag, input int nf, input int gmax);
        int o0, d0;
        o0 = outs;
        d0 = dones;
        for (int f = 0; f < nf; f++) send_frame(8'(f * 8'h80), gmax);
        drain();
        chk({tag, "_nout"}, outs - o0, 8 * nf);
        chk({tag, "_ndone"}, dones - d0, nf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        chk("rst_valid", {31'd0, o_pixel_valid}, 0);
        chk("rst_done", {31'd0, o_frame_done}, 0);
        i_rst_n = 1'b1;
        #2;
        chk("rel_valid", {31'd0, o_pixel_valid}, 0);
        chk("rel_pix", {8'd0, o_pixel_1, o_pixel_2, o_pixel_3}, 0);
        chk("rel_ack", {31'd0, o_pixel_ack}, 1);
        @(negedge i_clk);

        run_frames("cont", 1, 0);

        bp_en = 1;
        hold_cnt = 0;
        run_frames("bp", 1, 0);
        chk("bp_held", hold_cnt, 4);
        bp_en = 0;

        run_frames("gap", 1, 3);
        run_frames("b2b", 2, 0);

        cur_base = 0;
        for (int k = 0; k < 7; k++) send(8'((k / 4) * 16 + k % 4), 1'b0, 0);
        do_reset(1'b0);
        @(negedge i_clk);
        run_frames("rst12", 1, 0);

        for (int k = 0; k < 10; k++) send(8'((k / 4) * 16 + k % 4), 1'b0, 0);
        do_reset(1'b1);
        @(negedge i_clk);
        run_frames("rst21", 1, 0);

        ack_rand = 1;
        run_frames("rand", 1, 2);
        ack_rand = 0;
        drain();

`ifdef LINE_WINDOW_SOF_EN
        begin
            int o0, d0;
            chk_const = 0;
            o0 = outs;
            d0 = dones;
            for (int k = 0; k < 9; k++) send(8'((k / 4) * 16 + k % 4), 1'b0, 0);
            send(8'h21, 1'b1, 0);
            for (int k = 0; k < 15; k++) send(8'(8'h22 + k), 1'b0, 0);
            drain();
            chk("sof_nout", outs - o0, 9);
            chk("sof_ndone", dones - d0, 1);
            chk_const = 1;
            run_frames("sof_after", 1, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Raster-to-column window generator that feeds the 3x3 filter stage.
- Accepts one 8-bit pixel per transfer in raster order and buffers the two previous image lines.
- For each pixel at (row r, col c) with r>=2, emits three vertically aligned pixels: (r-2,c), (r-1,c), (r,c).
- Sits between the pixel source (DMA/stream) and the x/y filter blocks, using the same valid/ack handshake on both sides.

Parameters:
- IMG_WIDTH, 512, pixels per line; legal range 2..4096.
- IMG_HEIGHT, 512, lines per frame; legal range 3..4096.
- PIX_W, 8, pixel width in bits.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixel  in  PIX_W  raster input pixel.
- i_pixel_valid  in  1  input pixel valid.
- o_pixel_ack  out  1  input accept; input transfer = i_pixel_valid & o_pixel_ack.
- o_pixel_1  out  PIX_W  pixel from row r-2 (oldest line).
- o_pixel_2  out  PIX_W  pixel from row r-1.
- o_pixel_3  out  PIX_W  pixel from row r (current input).
- o_pixel_valid  out  1  window column valid.
- i_pixel_ack  in  1  downstream accept; output transfer = o_pixel_valid & i_pixel_ack.
- o_frame_done  out  1  one-cycle pulse on the input transfer of the last pixel of a frame.

Behaviour:
- Reset (async assert, synchronous release): o_pixel_valid=0, o_pixel_1/2/3=0, o_frame_done=0, col=0, row=0, state=FILL, line-select=0. Line RAM contents are not cleared.
- o_pixel_ack = ~o_pixel_valid | i_pixel_ack. Single output register; no skid buffer.
- Line storage: two line RAMs, A and B, each IMG_WIDTH x PIX_W, with asynchronous read. line-select names the RAM holding row r-1; the other RAM holds row r-2.
- On every input transfer:
  - Read both RAMs at address col.
  - Write i_pixel into the r-2 RAM at address col (read-before-write at the same address; the old value is used).
  - col increments. At col==IMG_WIDTH-1 it wraps to 0, row increments, and line-select toggles.
- State FILL (row 0..1): no output is produced. Transition to STREAM on the transfer with row==1 and col==IMG_WIDTH-1.
- State STREAM (row>=2): each input transfer loads o_pixel_1=RAM[r-2][col], o_pixel_2=RAM[r-1][col], o_pixel_3=i_pixel, and sets o_pixel_valid=1.
- Latency: o_pixel_valid rises one cycle after the input transfer.
- Output register update:
  - An output transfer with no new load clears o_pixel_valid.
  - An output transfer and a new load in the same cycle keep valid=1 with the new data.
  - While o_pixel_valid & ~i_pixel_ack, the outputs are held stable and input is stalled.
- End of frame: on the transfer with row==IMG_HEIGHT-1 and col==IMG_WIDTH-1:
  - o_frame_done pulses for 1 cycle.
  - row and col return to 0, line-select returns to 0, state returns to FILL.
  - The final window column is still emitted normally.
- Outputs per frame: exactly (IMG_HEIGHT-2)*IMG_WIDTH.
- i_pixel_valid deasserting mid-line: counters hold; there is no timeout.
- Reset mid-frame: all counters, state and o_pixel_valid clear immediately; the next pixel is treated as (0,0).
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT), with no overflow beyond the wrap points.

Optional Feature:
- Macro LINE_WINDOW_SOF_EN.
- Defined:
  - Adds input port i_sof (1 bit), sampled only on an input transfer.
  - When i_sof=1, that pixel is forced to be (0,0): col/row/line-select/state are reset before the pixel is processed, then it is written as col 0.
  - A partial previous frame is abandoned without asserting o_frame_done.
- Not defined: no i_sof port; framing is purely by count.

Decomposition:
- Package line_window_pkg:
  - PIX_W default.
  - State enum {FILL, STREAM}.
  - Localparams COL_W/ROW_W derived via $clog2.
- Sub-module line_ram: simple dual-port RAM, one synchronous write port and one asynchronous read port, depth/width parameterised. Instantiated twice.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*16+col):
- Continuous stream with i_pixel_ack=1:
  - No o_pixel_valid during rows 0-1.
  - First output = (0x00, 0x10, 0x20) one cycle after pixel 0x20 is accepted.
  - Exactly 8 outputs per frame; the last output is (0x13, 0x23, 0x33).
- Backpressure: hold i_pixel_ack=0 at the second STREAM output.
  - o_pixel_ack=0 and outputs stable at (0x01, 0x11, 0x21).
  - Release -> next output is (0x02, 0x12, 0x22), with no loss or duplication.
- Gapped input: i_pixel_valid toggled randomly.
  - The output sequence is identical to the continuous run.
  - o_frame_done pulses once, on the 0x33 transfer.
- Two back-to-back frames, second frame values +0x80:
  - Second frame first output = (0x80, 0x90, 0xA0), proving no line carry-over between frames.
- Reset asserted after pixel 0x12:
  - o_pixel_valid drops asynchronously.
  - The restarted frame produces first output (0x00, 0x10, 0x20).
- With LINE_WINDOW_SOF_EN:
  - i_sof=1 at pixel 0x21 of frame 1 restarts counting.
  - Output begins after two further full lines; o_frame_done is not pulsed for the aborted frame.
